// File: rtl/isdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// isdu_ctrl_if -- bundle between the ISDU controller and the LC-3 datapath.
//
// Contents:
//   Run, Continue        operator start / resume requests (datapath -> ctrl)
//   Opcode, IR_5, IR_11  instruction fields used for decode (datapath -> ctrl)
//   BEN                  registered branch-enable (datapath -> ctrl)
//   LD_*                 register load enables (ctrl -> datapath)
//   Gate*                bus drivers, at most one per cycle (ctrl -> datapath)
//   PCMUX, ADDR2MUX,
//   ALUK, DRMUX, SR1MUX,
//   SR2MUX, ADDR1MUX     datapath selects (ctrl -> datapath)
//   MIO_EN               MDR source: 1 = memory, 0 = bus
//   Mem_OE_n, Mem_WE_n   memory strobes, active-low
//   State                current controller state, for debug
//
// Handshake: there is no valid/ready pair here. Run and Continue are level
// requests sampled on rising Clk only in the states that honour them; every
// control output is a pure function of the current state (plus IR_5 and the
// wait counter), valid for the whole cycle.
//
// Modports: master = controller side, slave = datapath / testbench side.
// -----------------------------------------------------------------------------
interface isdu_ctrl_if;
   logic       Run;
   logic       Continue;
   logic [3:0] Opcode;
   logic       IR_5;
   logic       IR_11;
   logic       BEN;

   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX;
   logic [1:0] ADDR2MUX;
   logic [1:0] ALUK;
   logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
   logic       MIO_EN;
   logic       Mem_OE_n, Mem_WE_n;
   logic [4:0] State;

   modport master (
      input  Run, Continue, Opcode, IR_5, IR_11, BEN,
      output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
      output GatePC, GateMDR, GateALU, GateMARMUX,
      output PCMUX, ADDR2MUX, ALUK,
      output DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
      output MIO_EN, Mem_OE_n, Mem_WE_n, State
   );

   modport slave (
      output Run, Continue, Opcode, IR_5, IR_11, BEN,
      input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
      input  GatePC, GateMDR, GateALU, GateMARMUX,
      input  PCMUX, ADDR2MUX, ALUK,
      input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
      input  MIO_EN, Mem_OE_n, Mem_WE_n, State
   );
endinterface

// File: rtl/isdu_ctrl.sv
// -----------------------------------------------------------------------------
// isdu_ctrl -- LC-3 instruction sequencer / decode unit (Moore FSM).
//
// Ports:
//   Clk    in  clock, all state changes on the rising edge
//   Reset  in  synchronous, active-high; forces HALTED and clears the wait
//              counter from any state, taking priority over Run/Continue
//   bus    isdu_ctrl_if.master -- decode inputs in, datapath controls out,
//              plus State (debug view of the FSM encoding)
//
// Parameter:
//   MEM_WAIT  memory access cycles per read/write (1..7)
//
// Memory states (S33, S25, S16) dwell MEM_WAIT cycles using a 3-bit counter
// that is zero on entry and only counts while the FSM stays put, so it peaks
// at MEM_WAIT-1 and never wraps.
// -----------------------------------------------------------------------------
module isdu_ctrl #(
   parameter int MEM_WAIT = 2
) (
   input  logic         Clk,
   input  logic         Reset,
   isdu_ctrl_if.master  bus
);

   typedef enum logic [4:0] {
      HALTED = 5'd0,  S18    = 5'd1,  S33    = 5'd2,  S35 = 5'd3,
      S32    = 5'd4,  S01    = 5'd5,  S05    = 5'd6,  S09 = 5'd7,
      S00    = 5'd8,  S22    = 5'd9,  S12    = 5'd10, S04 = 5'd11,
      S21    = 5'd12, S20    = 5'd13, S06    = 5'd14, S25 = 5'd15,
      S27    = 5'd16, S07    = 5'd17, S23    = 5'd18, S16 = 5'd19,
      PAUSE1 = 5'd20, PAUSE2 = 5'd21
   } state_t;

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

   state_t     state, state_next;
   logic [2:0] wait_cnt;
   logic       wait_last;
   logic       in_wait_state;

   assign wait_last     = (wait_cnt == WAIT_LAST);
   assign in_wait_state = (state == S33) || (state == S25) || (state == S16);
   assign bus.State     = state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= HALTED;
         wait_cnt <= 3'd0;
      end else begin
         state <= state_next;
         // Leaving any state zeroes the counter, so every entry starts at 0.
         if (state_next != state || !in_wait_state)
            wait_cnt <= 3'd0;
         else
            wait_cnt <= wait_cnt + 3'd1;
      end
   end

   always_comb begin
      state_next     = state;
      bus.LD_MAR     = 1'b0;
      bus.LD_MDR     = 1'b0;
      bus.LD_IR      = 1'b0;
      bus.LD_BEN     = 1'b0;
      bus.LD_CC      = 1'b0;
      bus.LD_REG     = 1'b0;
      bus.LD_PC      = 1'b0;
      bus.GatePC     = 1'b0;
      bus.GateMDR    = 1'b0;
      bus.GateALU    = 1'b0;
      bus.GateMARMUX = 1'b0;
      bus.PCMUX      = 2'd0;
      bus.ADDR2MUX   = 2'd0;
      bus.ALUK       = 2'd0;
      bus.DRMUX      = 1'b0;
      bus.SR1MUX     = 1'b0;
      bus.SR2MUX     = 1'b0;
      bus.ADDR1MUX   = 1'b0;
      bus.MIO_EN     = 1'b0;
      bus.Mem_OE_n   = 1'b1;
      bus.Mem_WE_n   = 1'b1;

      unique case (state)
         HALTED: if (bus.Run) state_next = S18;
         S18: begin
            bus.GatePC = 1'b1;
            bus.LD_MAR = 1'b1;
            bus.LD_PC  = 1'b1;
            state_next = S33;
         end
         S33, S25: begin
            // Memory read: MDR captures on the last wait cycle only.
            bus.Mem_OE_n = 1'b0;
            bus.MIO_EN   = 1'b1;
            bus.LD_MDR   = wait_last;
            if (wait_last) state_next = (state == S33) ? S35 : S27;
         end
         S35: begin
            bus.GateMDR = 1'b1;
            bus.LD_IR   = 1'b1;
            state_next  = S32;
         end
         S32: begin
            bus.LD_BEN = 1'b1;
            case (bus.Opcode)
               4'b0001: state_next = S01;
               4'b0101: state_next = S05;
               4'b1001: state_next = S09;
               4'b0000: state_next = S00;
               4'b1100: state_next = S12;
               4'b0100: state_next = S04;
               4'b0110: state_next = S06;
               4'b0111: state_next = S07;
               4'b1101: state_next = PAUSE1;
               default: state_next = S18;
            endcase
         end
         S01, S05, S09: begin
            bus.SR1MUX  = 1'b1;
            bus.SR2MUX  = bus.IR_5;
            bus.ALUK    = (state == S01) ? 2'd0 : (state == S05) ? 2'd1 : 2'd2;
            bus.GateALU = 1'b1;
            bus.LD_REG  = 1'b1;
            bus.LD_CC   = 1'b1;
            state_next  = S18;
         end
         S00: state_next = bus.BEN ? S22 : S18;
         S22, S21: begin
            bus.ADDR2MUX = (state == S22) ? 2'd2 : 2'd3;
            bus.PCMUX    = 2'd2;
            bus.LD_PC    = 1'b1;
            state_next   = S18;
         end
         S12, S20: begin
            bus.SR1MUX  = 1'b1;
            bus.ALUK    = 2'd3;
            bus.GateALU = 1'b1;
            bus.PCMUX   = 2'd1;
            bus.LD_PC   = 1'b1;
            state_next  = S18;
         end
         S04: begin
            bus.GatePC = 1'b1;
            bus.DRMUX  = 1'b1;
            bus.LD_REG = 1'b1;
            state_next = bus.IR_11 ? S21 : S20;
         end
         S06, S07: begin
            bus.SR1MUX     = 1'b1;
            bus.ADDR1MUX   = 1'b1;
            bus.ADDR2MUX   = 2'd1;
            bus.GateMARMUX = 1'b1;
            bus.LD_MAR     = 1'b1;
            state_next     = (state == S06) ? S25 : S23;
         end
         S27: begin
            bus.GateMDR = 1'b1;
            bus.LD_REG  = 1'b1;
            bus.LD_CC   = 1'b1;
            state_next  = S18;
         end
         S23: begin
            // Store data comes from the register file via ALU pass-through.
            bus.ALUK    = 2'd3;
            bus.GateALU = 1'b1;
            bus.LD_MDR  = 1'b1;
            state_next  = S16;
         end
         S16: begin
            bus.Mem_WE_n = 1'b0;
            if (wait_last) state_next = S18;
         end
         // Two-step pause so one Continue pulse yields exactly one resume.
         PAUSE1: if (bus.Continue)  state_next = PAUSE2;
         PAUSE2: if (!bus.Continue) state_next = S18;
         default: state_next = HALTED;
      endcase
   end

endmodule

// File: doc/isdu_ctrl.md
ISDU_CTRL -- requirements
Module: isdu_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WAIT, default 2: memory access cycles per read/write (legal 1..7).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  reset; synchronous, active-high.
- Run  in  1  start execution from Halted.
- Continue  in  1  resume from pause.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  immediate select for ADD/AND.
- IR_11  in  1  JSR vs JSRR select.
- BEN  in  1  registered branch-enable.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers.
- PCMUX  out  2  0 = PC+1, 1 = bus, 2 = address adder.
- ADDR2MUX  out  2  0 = zero, 1 = off6, 2 = off9, 3 = off11.
- ALUK  out  2  0 = add, 1 = and, 2 = not, 3 = pass.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1 each  datapath selects.
- MIO_EN  out  1  MDR source is memory (1) or bus (0).
- Mem_OE_n, Mem_WE_n  out  1 each  memory strobes, active-low.
- State  out  5  current state encoding, for debug.

Function
REQ-003 Every output SHALL default to 0 in each state unless that state asserts it. Exception: Mem_OE_n and Mem_WE_n SHALL default to 1.
REQ-004 States: HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12, S04, S21, S20, S06, S25, S27, S07, S23, S16, PAUSE1, PAUSE2.
REQ-005 HALTED SHALL go to S18 when Run=1, and otherwise stay in HALTED.
REQ-006 S18 (fetch) SHALL drive GatePC, LD_MAR, PCMUX=0 and LD_PC, then go to S33.
REQ-007 S33 SHALL hold for exactly MEM_WAIT cycles, driving Mem_OE_n=0 and MIO_EN=1 on every cycle. LD_MDR SHALL be asserted on the final cycle only. The block SHALL then go to S35.
REQ-008 S35 SHALL drive GateMDR and LD_IR, then go to S32.
REQ-009 S32 SHALL assert LD_BEN and decode Opcode as follows:
- 0001 -> S01; 0101 -> S05; 1001 -> S09; 0000 -> S00; 1100 -> S12; 0100 -> S04; 0110 -> S06; 0111 -> S07; 1101 -> PAUSE1.
- Any other opcode -> S18 (treated as no-op).
REQ-010 S01/S05 SHALL drive SR1MUX=1, SR2MUX=IR_5, ALUK=0 (S01) or 1 (S05), GateALU, LD_REG, DRMUX=0 and LD_CC, then go to S18.
REQ-011 S09 SHALL be the same as S01 but with ALUK=2, then go to S18.
REQ-012 S00 SHALL go to S22 if BEN=1, else to S18.
REQ-013 S22 SHALL drive ADDR1MUX=0, ADDR2MUX=2, PCMUX=2 and LD_PC, then go to S18.
REQ-014 S12 SHALL drive SR1MUX=1, ALUK=3, GateALU, PCMUX=1 and LD_PC, then go to S18.
REQ-015 S04 SHALL drive GatePC, DRMUX=1 and LD_REG, then go to S21 if IR_11=1, else to S20.
REQ-016 S21 SHALL drive ADDR1MUX=0, ADDR2MUX=3, PCMUX=2 and LD_PC. S20 SHALL drive SR1MUX=1, ALUK=3, GateALU, PCMUX=1 and LD_PC. Both SHALL then go to S18.
REQ-017 S06/S07 SHALL drive SR1MUX=1, ADDR1MUX=1, ADDR2MUX=1, GateMARMUX and LD_MAR, then go to S25 (S06) or S23 (S07).
REQ-018 S25 SHALL behave as S33 (MEM_WAIT-cycle read), then go to S27.
REQ-019 S27 SHALL drive GateMDR, DRMUX=0, LD_REG and LD_CC, then go to S18.
REQ-020 S23 SHALL drive SR1MUX=0, ALUK=3, GateALU, MIO_EN=0 and LD_MDR, then go to S16.
REQ-021 S16 SHALL hold for exactly MEM_WAIT cycles with Mem_WE_n=0, then go to S18.
REQ-022 PAUSE1 SHALL stay while Continue=0 and go to PAUSE2 on Continue=1. PAUSE2 SHALL stay while Continue=1 and go to S18 on Continue=0, so that exactly one resume occurs per Continue pulse.
REQ-023 The wait counter SHALL be 3 bits wide. It SHALL be cleared on every entry to S33, S25 or S16, and SHALL never wrap within a state.
REQ-024 Run and Continue SHALL be ignored in every state not named in REQ-005 and REQ-022.
REQ-025 At most one Gate* output SHALL be asserted in any cycle.
REQ-026 Mem_OE_n and Mem_WE_n SHALL never both be 0 in the same cycle.

Reset
REQ-027 Reset=1 at a clock edge SHALL force HALTED and clear the wait counter, from any state including mid-memory-access. All outputs SHALL hold their REQ-003 defaults in the following cycle.
REQ-028 Reset SHALL take priority over Run and Continue.

Verification
REQ-029 Reset, then Run pulse with MEM_WAIT=2: State sequence HALTED, S18, S33, S33, S35, S32. LD_MDR is high only on the 2nd S33 cycle.
REQ-030 Opcode=0001, IR_5=1 at S32: next state S01 with SR2MUX=1, ALUK=0, LD_REG=1, LD_CC=1; following state S18.
REQ-031 Opcode=0000: BEN=0 -> S00 then S18 with LD_PC=0; BEN=1 -> S00, S22 (PCMUX=2, LD_PC=1), then S18.
REQ-032 Opcode=0111 with MEM_WAIT=3: sequence S07, S23, S16×3 with Mem_WE_n=0 on all three S16 cycles, then S18; Mem_OE_n=1 throughout.
REQ-033 Opcode=1101: state holds in PAUSE1 for 10 cycles with Continue=0. Continue held 1 for 5 cycles keeps state in PAUSE2; Continue dropped to 0 -> S18.
REQ-034 Reset asserted during 1st S25 cycle: next state HALTED, Mem_OE_n=1, LD_REG=0; a later Run restarts at S18.
